// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, one-hot op indices,
// operand formats and the decoded-entry payload.
// Optional feature macro: RV_DECODE_M_EXT_EN (adds the M-extension ops 37-44).
package rv_decode_pkg;

  // Widest PC the entry can carry; the stage truncates to its PC_W (<= 64).
  localparam int unsigned PC_MAX_W = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int unsigned OP_ADD = 0,  OP_SUB = 1,  OP_XOR = 2,  OP_OR = 3,  OP_AND = 4;
  localparam int unsigned OP_SLL = 5,  OP_SRL = 6,  OP_SRA = 7,  OP_SLT = 8, OP_SLTU = 9;
  localparam int unsigned OP_ADDI = 10, OP_XORI = 11, OP_ORI = 12, OP_ANDI = 13, OP_SLLI = 14;
  localparam int unsigned OP_SRLI = 15, OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18;
  localparam int unsigned OP_LB = 19, OP_LH = 20, OP_LW = 21, OP_LBU = 22, OP_LHU = 23;
  localparam int unsigned OP_SB = 24, OP_SH = 25, OP_SW = 26;
  localparam int unsigned OP_BEQ = 27, OP_BNE = 28, OP_BLT = 29, OP_BGE = 30;
  localparam int unsigned OP_BLTU = 31, OP_BGEU = 32;
  localparam int unsigned OP_JAL = 33, OP_JALR = 34, OP_LUI = 35, OP_AUIPC = 36;
  localparam int unsigned OP_MUL = 37;  // mul..remu occupy 37-44 in func3 order

`ifdef RV_DECODE_M_EXT_EN
  localparam int unsigned OP_W = 45;
`else
  localparam int unsigned OP_W = 37;
`endif

  // Operand format; selects which fields are present and how imm is built.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  // One decoded instruction. imm is kept at 32 bits; it is a sign-extension
  // source, so widening to XLEN happens at the stage output.
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [31:0]         imm;
    logic                rs1_valid;
    logic                rs2_valid;
    logic                rd_valid;
    logic                func3_valid;
    logic                func7_valid;
    logic                imm_valid;
    logic [OP_W-1:0]     op;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I decoder: instruction word + pc -> entry_t.
// Ports: instr (32b word), pc (sideband, PC_MAX_W), entry_c (decoded entry).
// Fields absent from the format read as zero; an unrecognised encoding
// yields op=0, illegal=1 and all flags/fields zero.
// Optional feature macro: RV_DECODE_M_EXT_EN.
module rv_decode_comb
  import rv_decode_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [PC_MAX_W-1:0] pc,
  output entry_t              entry_c
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        hit;
  int unsigned op_idx;
  fmt_e        fmt;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Opcode/func selection of the op index and operand format.
  always_comb begin
    hit    = 1'b0;
    op_idx = 0;
    fmt    = FMT_NONE;
    case (opc)
      OPC_OP: begin
        fmt = FMT_R;
        case (f7)
          7'h00: begin
            hit = 1'b1;
            case (f3)
              3'd0:    op_idx = OP_ADD;
              3'd1:    op_idx = OP_SLL;
              3'd2:    op_idx = OP_SLT;
              3'd3:    op_idx = OP_SLTU;
              3'd4:    op_idx = OP_XOR;
              3'd5:    op_idx = OP_SRL;
              3'd6:    op_idx = OP_OR;
              default: op_idx = OP_AND;
            endcase
          end
          7'h20: begin
            if (f3 == 3'd0) begin hit = 1'b1; op_idx = OP_SUB; end
            if (f3 == 3'd5) begin hit = 1'b1; op_idx = OP_SRA; end
          end
`ifdef RV_DECODE_M_EXT_EN
          7'h01: begin
            hit    = 1'b1;
            op_idx = OP_MUL + 32'(f3);
          end
`endif
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        hit = 1'b1;
        case (f3)
          3'd0: op_idx = OP_ADDI;
          3'd2: op_idx = OP_SLTI;
          3'd3: op_idx = OP_SLTIU;
          3'd4: op_idx = OP_XORI;
          3'd6: op_idx = OP_ORI;
          3'd7: op_idx = OP_ANDI;
          3'd1: begin
            fmt    = FMT_SH;
            op_idx = OP_SLLI;
            hit    = (f7 == 7'h00);
          end
          default: begin
            // f3 == 5: funct7 picks logical vs arithmetic right shift
            fmt    = FMT_SH;
            op_idx = (f7 == 7'h20) ? OP_SRAI : OP_SRLI;
            hit    = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        hit = 1'b1;
        case (f3)
          3'd0:    op_idx = OP_LB;
          3'd1:    op_idx = OP_LH;
          3'd2:    op_idx = OP_LW;
          3'd4:    op_idx = OP_LBU;
          3'd5:    op_idx = OP_LHU;
          default: hit = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        hit = 1'b1;
        case (f3)
          3'd0:    op_idx = OP_SB;
          3'd1:    op_idx = OP_SH;
          3'd2:    op_idx = OP_SW;
          default: hit = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        hit = 1'b1;
        case (f3)
          3'd0:    op_idx = OP_BEQ;
          3'd1:    op_idx = OP_BNE;
          3'd4:    op_idx = OP_BLT;
          3'd5:    op_idx = OP_BGE;
          3'd6:    op_idx = OP_BLTU;
          3'd7:    op_idx = OP_BGEU;
          default: hit = 1'b0;
        endcase
      end
      OPC_JAL:   begin fmt = FMT_J; hit = 1'b1;          op_idx = OP_JAL;   end
      OPC_JALR:  begin fmt = FMT_I; hit = (f3 == 3'd0);  op_idx = OP_JALR;  end
      OPC_LUI:   begin fmt = FMT_U; hit = 1'b1;          op_idx = OP_LUI;   end
      OPC_AUIPC: begin fmt = FMT_U; hit = 1'b1;          op_idx = OP_AUIPC; end
      default: ;
    endcase
  end

  // Format-driven field extraction, immediate assembly and one-hot op.
  always_comb begin
    entry_c    = '0;
    entry_c.pc = pc;
    if (!hit) begin
      entry_c.illegal = 1'b1;
    end else begin
      entry_c.op          = OP_W'(1) << op_idx;
      entry_c.rs1_valid   = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SH) ||
                            (fmt == FMT_S) || (fmt == FMT_B);
      entry_c.rs2_valid   = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
      entry_c.rd_valid    = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SH) ||
                            (fmt == FMT_U) || (fmt == FMT_J);
      entry_c.func3_valid = entry_c.rs1_valid;
      entry_c.func7_valid = (fmt == FMT_R) || (fmt == FMT_SH);
      entry_c.imm_valid   = (fmt != FMT_R);
      if (entry_c.rs1_valid)   entry_c.rs1   = instr[19:15];
      if (entry_c.rs2_valid)   entry_c.rs2   = instr[24:20];
      if (entry_c.rd_valid)    entry_c.rd    = instr[11:7];
      if (entry_c.func3_valid) entry_c.func3 = f3;
      if (entry_c.func7_valid) entry_c.func7 = f7;
      case (fmt)
        FMT_I:   entry_c.imm = {{20{instr[31]}}, instr[31:20]};
        FMT_SH:  entry_c.imm = {27'b0, instr[24:20]};  // shamt only
        FMT_S:   entry_c.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        FMT_B:   entry_c.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
        FMT_U:   entry_c.imm = {instr[31:12], 12'b0};
        FMT_J:   entry_c.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
        default: entry_c.imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Handshaked RV32I decode stage with a 2-entry skid buffer.
// Ports: clk, rst_n (async active-low), flush (sync discard);
//   fetch side  in_valid/in_ready/in_instr/in_pc;
//   execute side out_valid/out_ready/out_pc, rs1/rs2/rd, func3/func7,
//   imm (XLEN, sign-extended), *_valid field flags, op (one-hot), illegal.
// Parameters: XLEN (32 or 64), PC_W (<= 64).
// Optional feature macro: RV_DECODE_M_EXT_EN (M-extension ops, OP_W=45).
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] imm,
  output logic            rs1_valid,
  output logic            rs2_valid,
  output logic            rd_valid,
  output logic            func3_valid,
  output logic            func7_valid,
  output logic            imm_valid,
  output logic [OP_W-1:0] op,
  output logic            illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d, skid_q, skid_d, dec_c;
  logic       in_xfer, out_xfer;
  logic       unused_pc_bits;

  rv_decode_comb u_comb (
    .instr   (in_instr),
    .pc      (PC_MAX_W'(in_pc)),
    .entry_c (dec_c)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next state and entry-register updates; flush wins over any transfer.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            head_d  = dec_c;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = dec_c;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            skid_d  = dec_c;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, entries and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      in_ready  <= (state_d != ST_TWO);
      out_valid <= (state_d != ST_EMPTY);
    end
  end

  assign out_pc      = PC_W'(head_q.pc);
  assign rs1         = head_q.rs1;
  assign rs2         = head_q.rs2;
  assign rd          = head_q.rd;
  assign func3       = head_q.func3;
  assign func7       = head_q.func7;
  assign imm         = XLEN'($signed(head_q.imm));
  assign rs1_valid   = head_q.rs1_valid;
  assign rs2_valid   = head_q.rs2_valid;
  assign rd_valid    = head_q.rd_valid;
  assign func3_valid = head_q.func3_valid;
  assign func7_valid = head_q.func7_valid;
  assign imm_valid   = head_q.imm_valid;
  assign op          = head_q.op;
  assign illegal     = head_q.illegal;

  // PC bits above PC_W are never observed.
  assign unused_pc_bits = ^head_q.pc;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;
`ifdef RV_DECODE_M_EXT_EN
  localparam int unsigned OPW = 45;
`else
  localparam int unsigned OPW = 37;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] imm;
  logic            rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid;
  logic [OPW-1:0]  op;
  logic            illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3), .func7(func7), .imm(imm),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid),
    .func3_valid(func3_valid), .func7_valid(func7_valid), .imm_valid(imm_valid),
    .op(op), .illegal(illegal)
  );

  // flags = {rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid}
  typedef struct {
    logic [31:0] instr;
    int          op_idx;   // -1: illegal
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  flags;
  } vec_t;

  localparam logic [5:0] FL_R  = 6'b111110;
  localparam logic [5:0] FL_I  = 6'b101101;
  localparam logic [5:0] FL_SH = 6'b101111;
  localparam logic [5:0] FL_SB = 6'b110101;
  localparam logic [5:0] FL_UJ = 6'b001001;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    logic [63:0] w;
    w = {{32{v[31]}}, v};
    return w[XLEN-1:0];
  endfunction

  task automatic check_entry(input vec_t v, input logic [PC_W-1:0] pc, input int i);
    logic [OPW-1:0] exp_op;
    exp_op = '0;
    if (v.op_idx >= 0) exp_op[v.op_idx] = 1'b1;
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d op", i), 64'(op), 64'(exp_op));
    chk($sformatf("v%0d illegal", i), 64'(illegal), 64'(v.op_idx < 0));
    chk($sformatf("v%0d imm", i), 64'(imm), 64'(sext(v.imm)));
    chk($sformatf("v%0d regs", i), 64'({rs1, rs2, rd}), 64'({v.rs1, v.rs2, v.rd}));
    chk($sformatf("v%0d funcs", i), 64'({func3, func7}), 64'({v.f3, v.f7}));
    chk($sformatf("v%0d flags", i),
        64'({rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid}),
        64'(v.flags));
    chk($sformatf("v%0d pc", i), 64'(out_pc), 64'(pc));
  endtask

  task automatic push(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  logic [PC_W-1:0] got[$];
  logic            acc;

  initial begin
    vecs[0]  = '{32'hFFF00093, 10, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, FL_I};   // addi x1,x0,-1
    vecs[1]  = '{32'h402081B3,  1, 32'h0,        5'd1, 5'd2, 5'd3, 3'd0, 7'h20, FL_R};   // sub
    vecs[2]  = '{32'h4032D293, 16, 32'h3,        5'd5, 5'd0, 5'd5, 3'd5, 7'h20, FL_SH};  // srai
    vecs[3]  = '{32'hFE208EE3, 27, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, FL_SB};  // beq -4
    vecs[4]  = '{32'h123452B7, 35, 32'h12345000, 5'd0, 5'd0, 5'd5, 3'd0, 7'h00, FL_UJ};  // lui
    vecs[5]  = '{32'h80000097, 36, 32'h80000000, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, FL_UJ};  // auipc
    vecs[6]  = '{32'h008000EF, 33, 32'h8,        5'd0, 5'd0, 5'd1, 3'd0, 7'h00, FL_UJ};  // jal +8
    vecs[7]  = '{32'h00008067, 34, 32'h0,        5'd1, 5'd0, 5'd0, 3'd0, 7'h00, FL_I};   // jalr
    vecs[8]  = '{32'h0041A103, 21, 32'h4,        5'd3, 5'd0, 5'd2, 3'd2, 7'h00, FL_I};   // lw
    vecs[9]  = '{32'hFE512C23, 26, 32'hFFFFFFF8, 5'd2, 5'd5, 5'd0, 3'd2, 7'h00, FL_SB};  // sw -8
    vecs[10] = '{32'h0062B233,  9, 32'h0,        5'd5, 5'd6, 5'd4, 3'd3, 7'h00, FL_R};   // sltu
    vecs[11] = '{32'h0020F863, 32, 32'h10,       5'd1, 5'd2, 5'd0, 3'd7, 7'h00, FL_SB};  // bgeu +16
    vecs[12] = '{32'h403150B3,  7, 32'h0,        5'd2, 5'd3, 5'd1, 3'd5, 7'h20, FL_R};   // sra
    vecs[13] = '{32'h00000000, -1, 32'h0,        5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 6'b0};   // all-zero word
    vecs[14] = '{32'h40109093, -1, 32'h0,        5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 6'b0};   // slli f7=0x20
`ifdef RV_DECODE_M_EXT_EN
    vecs[15] = '{32'h023100B3, 37, 32'h0,        5'd2, 5'd3, 5'd1, 3'd0, 7'h01, FL_R};   // mul
`else
    vecs[15] = '{32'h023100B3, -1, 32'h0,        5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 6'b0};   // mul w/o M
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst op_illegal_imm", 64'({op != '0, illegal, imm != '0}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream with execute always ready: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(vecs[i].instr, PC_W'(32'h1000 + 4 * i));
      check_entry(vecs[i], PC_W'(32'h1000 + 4 * i), i);
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: two accepted, third held off, then drained in order
    out_ready = 1'b0;
    push(32'h00100093, PC_W'(32'h2000));
    chk("bp in_ready after 1", 64'(in_ready), 64'd1);
    push(32'h00200093, PC_W'(32'h2004));
    chk("bp in_ready after 2", 64'(in_ready), 64'd0);
    chk("bp head pc", 64'(out_pc), 64'h2000);
    push(32'h00300093, PC_W'(32'h2008));
    chk("bp held in_ready", 64'(in_ready), 64'd0);
    chk("bp held head pc", 64'(out_pc), 64'h2000);
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) got.push_back(out_pc);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp drained count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < got.size()) chk($sformatf("bp order %0d", k), 64'(got[k]), 64'(32'h2000 + 4 * k));
    chk("bp empty after drain", 64'(out_valid), 64'd0);
    chk("bp in_valid consumed", 64'(in_valid), 64'd0);

    // Flush while full: simultaneous input is discarded
    @(negedge clk);
    out_ready = 1'b0;
    push(32'h00100093, PC_W'(32'h3000));
    push(32'h00200093, PC_W'(32'h3004));
    chk("fl full in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h00500093;
    in_pc     = PC_W'(32'h3008);
    @(posedge clk);
    #1;
    chk("fl out_valid", 64'(out_valid), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("fl not captured", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-operation clears without a clock edge
    push(32'hFFF00093, PC_W'(32'h4000));
    chk("ar loaded", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar out_valid", 64'(out_valid), 64'd0);
    chk("ar imm", 64'(imm), 64'd0);
    chk("ar op", 64'(op), 64'd0);
    chk("ar in_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
